// File: rtl/rom_loader.sv
// UART (8N1) boot loader: writes a length-prefixed big-endian word image into ROM and holds the core in reset until done.
// Latency: o_we rises 1 cycle after the 4th byte's stop sample; no backpressure, since the serial line cannot be stalled.
module rom_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int MAX_WORDS    = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx,
   output logic        o_we,
   output logic [31:0] o_addr,
   output logic [31:0] o_data,
   output logic        o_cpu_rst,
   output logic        o_busy,
   output logic        o_err
);

   localparam int TW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [31:0]   MAX_W32 = MAX_WORDS;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LEN_HI, LEN_LO, LOAD, DONE} ld_state_t;

   logic          rx_meta;
   logic          rx_s;
   rx_state_t     rx_state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          byte_valid;
   logic          frame_err;

   ld_state_t     ld_state;
   logic [7:0]    len_hi;
   logic [15:0]   len;
   logic [23:0]   word;
   logic [1:0]    byte_cnt;
   logic [15:0]   word_idx;
   logic          last_word;
   logic [15:0]   len_next;

   assign len_next = {len_hi, shreg};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   // Start bit is checked at its midpoint; every later sample lands one full bit on.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state   <= RX_IDLE;
         timer      <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_s) begin
                  rx_state <= RX_START;
                  timer    <= '0;
               end
            end
            RX_START: begin
               if (timer == HALF_M1) begin
                  timer   <= '0;
                  bit_cnt <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_DATA: begin
               if (timer == FULL_M1) begin
                  timer   <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     rx_state <= RX_STOP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            RX_STOP: begin
               if (timer == FULL_M1) begin
                  timer    <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_s)
                     byte_valid <= 1'b1;
                  else
                     frame_err  <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ld_state  <= LEN_HI;
         len_hi    <= '0;
         len       <= '0;
         word      <= '0;
         byte_cnt  <= '0;
         word_idx  <= '0;
         last_word <= 1'b0;
         o_we      <= 1'b0;
         o_addr    <= '0;
         o_data    <= '0;
         o_cpu_rst <= 1'b1;
         o_busy    <= 1'b1;
         o_err     <= 1'b0;
      end else begin
         o_we <= 1'b0;
         if (frame_err)
            o_err <= 1'b1;
         case (ld_state)
            LEN_HI: begin
               if (byte_valid) begin
                  len_hi   <= shreg;
                  ld_state <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (byte_valid) begin
                  len       <= len_next;
                  byte_cnt  <= '0;
                  word_idx  <= '0;
                  last_word <= 1'b0;
                  if (len_next == 16'd0) begin
                     ld_state  <= DONE;
                     o_cpu_rst <= 1'b0;
                     o_busy    <= 1'b0;
                  end else if ({16'd0, len_next} > MAX_W32) begin
                     o_err    <= 1'b1;
                     ld_state <= LEN_HI;
                  end else begin
                     ld_state <= LOAD;
                  end
               end
            end
            LOAD: begin
               // last_word is only set alongside o_we, so DONE follows the final strobe by one cycle.
               if (last_word) begin
                  ld_state  <= DONE;
                  o_cpu_rst <= 1'b0;
                  o_busy    <= 1'b0;
               end else if (byte_valid) begin
                  word     <= {word[15:0], shreg};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     o_we      <= 1'b1;
                     o_data    <= {word, shreg};
                     o_addr    <= {14'd0, word_idx, 2'b00};
                     word_idx  <= word_idx + 16'd1;
                     last_word <= (word_idx == len - 16'd1);
                  end
               end
            end
            DONE: begin
               o_cpu_rst <= 1'b0;
               o_busy    <= 1'b0;
            end
            default: ld_state <= LEN_HI;
         endcase
      end
   end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
Serial boot loader upstream of the processor core. It receives a program image over a UART line (8N1) and writes it word by word into instruction ROM at byte addresses 0, 4, 8, … so that it matches the PC stepping by 4. It holds the core in reset until the last word is written, then releases it.

Parameters:
CLKS_PER_BIT, 16, i_clk cycles per UART bit; must be an even value ≥ 4.
MAX_WORDS, 1024, instruction ROM capacity in 32-bit words.

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_rx  input  1  UART receive line; idles high
o_we  output  1  ROM write strobe; one-cycle pulse per word
o_addr  output  32  ROM byte address; always a multiple of 4
o_data  output  32  instruction word to write
o_cpu_rst  output  1  reset to the core; high while loading
o_busy  output  1  high until the image is complete
o_err  output  1  sticky error flag: frame error or oversize length

Behaviour:
- Reset is asynchronous and active-high on i_rst. All state is cleared.
  - Reset values: o_we=0, o_addr=0, o_data=0, o_cpu_rst=1, o_busy=1, o_err=0.
  - Byte and word counters and the length register are cleared.
  - Reset in the middle of a load aborts it. The core stays in reset and the loader waits for a new length header.
- i_rx passes through a 2-flop synchronizer before use. All timing below is measured on the synchronized signal (rx_s).
- UART receive FSM has states RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a low on rx_s moves to RX_START and clears the bit timer.
  - RX_START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - Low: go to RX_DATA.
    - High: false start; return to RX_IDLE with no error.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, shifting into the byte register.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - High: byte_valid pulses for one cycle.
    - Low: the byte is discarded and o_err is set.
  - In both cases the FSM returns to RX_IDLE.
- Load FSM has states LEN_HI, LEN_LO, LOAD, DONE.
  - LEN_HI: first valid byte becomes the length high byte.
  - LEN_LO: second valid byte becomes the low byte. N = {hi, lo} is the 16-bit word count.
    - N=0: go to DONE.
    - N>MAX_WORDS: set o_err and go to LEN_HI; the header is rejected.
    - Otherwise: go to LOAD.
  - LOAD: bytes are assembled big-endian (first byte goes to bits [31:24]).
    - On the 4th byte, in the cycle after its byte_valid: o_we=1 for one cycle, o_data=word, o_addr=4*word_idx.
    - word_idx then increments and the byte counter wraps to 0.
    - After word N-1 is written, go to DONE in the cycle following the o_we pulse.
  - DONE: o_cpu_rst=0 and o_busy=0, registered and entered one cycle after the last o_we. Further received bytes are ignored; o_we stays 0.
- o_addr and o_data hold their last values between strobes.
- o_err is sticky. Only i_rst clears it. It does not stop the load FSM; a discarded byte simply shifts alignment, and the bench must detect that through o_err.
- Width rules: word_idx is 16 bits, zero-extended and shifted left by 2 to form o_addr. There is no wrap inside LOAD because N ≤ MAX_WORDS.

Test Plan:
1. CLKS_PER_BIT=4. Send 00 02 | 12 34 56 78 | 9A BC DE F0.
   → o_we pulses twice: (addr 0, data 0x12345678), then (addr 4, data 0x9ABCDEF0).
   → o_cpu_rst falls 1 cycle after the 2nd pulse; o_err=0.
2. Send 00 00.
   → No o_we pulse; o_cpu_rst=0 one cycle after the low byte is accepted.
   → Later bytes AA BB CC DD produce no o_we.
3. 0.25-bit low glitch on i_rx, then send 00 01 01 02 03 04.
   → Glitch ignored; a single write (addr 0, data 0x01020304); o_err=0.
4. Byte with stop bit driven 0.
   → Byte dropped, o_err=1 and held until i_rst.
   → With MAX_WORDS=4, header 00 05 → o_err=1, FSM back in LEN_HI, o_cpu_rst stays 1.
5. Send 00 03 plus 5 data bytes, then assert i_rst asynchronously mid-bit.
   → All outputs return to reset values immediately.
   → A fresh 00 01 11 22 33 44 → write (addr 0, data 0x11223344), then release.
